// File: rtl/pulse_slot_decoder.sv
// pulse_slot_decoder
//
// Monitor and checker for slot-gated clock-pulse streams. A one-cycle sync
// strobe marks slot 0 of each 2^CNT_W-slot frame. Every frame reports which
// slots carried pulses and how many pulses there were. The block reports
// lock once LOCK_FRAMES identical good frames have been seen in a row.
//
// Parameters
//   CNT_W        slot counter width; frame length is 2^CNT_W cycles
//   LOCK_FRAMES  consecutive identical good frames needed for lock (1..15)
//
// Ports
//   clk          system clock, posedge
//   rst          asynchronous active-low reset
//   sync_in      slot-0 strobe from the generator
//   pulse_in     gated pulse stream, one sample per slot
//   slot_a       lowest pulsed slot of the last completed frame
//   slot_b       second pulsed slot (equals slot_a for a single pulse)
//   pulse_cnt    pulses in the last frame, saturating at 3
//   frame_valid  one-cycle strobe when the slot/count outputs update
//   locked       pattern stable for LOCK_FRAMES frames
//   err          error indication (strobe, or sticky; see below)
//   err_clr      clears a sticky err (only with PULSE_SLOT_STICKY_ERR_EN)
//
// Build option
//   PULSE_SLOT_STICKY_ERR_EN  defined: err is sticky and the err_clr port is
//                             added. Undefined: err is a one-cycle strobe.
//
// state   | meaning
// --------+-------------------------------------------------------------
// UNSYNC  | no frame reference yet; pulses ignored until the first sync_in
// SEARCH  | framing known; counting identical good frames toward lock
// LOCKED  | pattern stable; any deviating frame or early sync drops lock

module pulse_slot_decoder #(
  parameter int CNT_W       = 3,
  parameter int LOCK_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] slot_a,
  output logic [CNT_W-1:0] slot_b,
  output logic [1:0]       pulse_cnt,
  output logic             frame_valid,
  output logic             locked,
  output logic             err
`ifdef PULSE_SLOT_STICKY_ERR_EN
  ,
  input  logic             err_clr
`endif
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_SLOT = '1;
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_FRAMES);

  state_t           state;
  logic [CNT_W-1:0] phase;
  logic [1:0]       acc_cnt;
  logic [CNT_W-1:0] acc_first;
  logic [CNT_W-1:0] acc_second;
  logic [3:0]       match_cnt;

  // ------------------------------------------------------------------
  // Slot tracking
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cur;
  logic             in_frame;
  logic             early_sync;
  logic             frame_end;

  always_comb begin
    cur        = sync_in ? '0 : phase;
    in_frame   = (state != ST_UNSYNC);
    // A sync that arrives away from slot 0 restarts the framing. In
    // UNSYNC the first sync is the normal entry point, not an error.
    early_sync = sync_in && (phase != '0) && in_frame;
    frame_end  = in_frame && (cur == LAST_SLOT);
  end

  // ------------------------------------------------------------------
  // Per-frame capture, including the pulse in the current slot
  // ------------------------------------------------------------------
  logic             capture;
  logic [1:0]       base_cnt;
  logic [1:0]       cnt_n;
  logic [CNT_W-1:0] first_n;
  logic [CNT_W-1:0] second_n;

  always_comb begin
    // The sync cycle that leaves UNSYNC is already slot 0 of a frame.
    capture  = pulse_in && (in_frame || sync_in);
    // Only the count has to be discarded on an early sync. The slot
    // registers are reloaded before they can be reported again.
    base_cnt = early_sync ? 2'd0 : acc_cnt;
    cnt_n    = base_cnt;
    first_n  = acc_first;
    second_n = acc_second;
    if (capture) begin
      cnt_n = (base_cnt == 2'd3) ? 2'd3 : base_cnt + 2'd1;
      if (base_cnt == 2'd0) begin
        first_n = cur;
      end
      if (base_cnt == 2'd1) begin
        second_n = cur;
      end
    end
  end

  // ------------------------------------------------------------------
  // Frame report and classification
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] rep_a;
  logic [CNT_W-1:0] rep_b;
  logic [1:0]       rep_cnt;
  logic             good;
  logic             same;
  logic [3:0]       match_nxt;
  logic             err_evt;

  always_comb begin
    rep_cnt = cnt_n;
    rep_a   = '0;
    rep_b   = '0;
    if (cnt_n != 2'd0) begin
      rep_a = first_n;
      rep_b = (cnt_n == 2'd1) ? first_n : second_n;
    end

    good = (rep_cnt == 2'd1) || (rep_cnt == 2'd2);
    // The output registers still hold the previous report, so they are
    // the reference for the stability comparison.
    same = good && (rep_a == slot_a) && (rep_b == slot_b) &&
           (rep_cnt == pulse_cnt);

    if (same) begin
      match_nxt = (match_cnt >= LOCK_N) ? LOCK_N : match_cnt + 4'd1;
    end else if (good) begin
      match_nxt = 4'd1;
    end else begin
      match_nxt = 4'd0;
    end

    err_evt = early_sync ||
              (frame_end && (!good || ((state == ST_LOCKED) && !same)));
  end

  // ------------------------------------------------------------------
  // Control FSM with registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_UNSYNC;
      phase       <= '0;
      acc_cnt     <= 2'd0;
      acc_first   <= '0;
      acc_second  <= '0;
      match_cnt   <= 4'd0;
      slot_a      <= '0;
      slot_b      <= '0;
      pulse_cnt   <= 2'd0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
    end else begin
      // The phase counter free-runs, so a missing sync is tolerated.
      phase       <= cur + 1'b1;
      frame_valid <= frame_end;
`ifdef PULSE_SLOT_STICKY_ERR_EN
      // A new error event wins over a clear in the same cycle.
      err         <= err_evt || (err && !err_clr);
`else
      err         <= err_evt;
`endif

      if (frame_end) begin
        slot_a     <= rep_a;
        slot_b     <= rep_b;
        pulse_cnt  <= rep_cnt;
        acc_cnt    <= 2'd0;
        acc_first  <= '0;
        acc_second <= '0;
        match_cnt  <= match_nxt;

        case (state)
          ST_SEARCH: begin
            if (match_nxt == LOCK_N) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end
          end
          ST_LOCKED: begin
            // match_nxt alone cannot decide this case. With LOCK_FRAMES=1
            // a differing good frame would otherwise keep lock.
            if (!same) begin
              state  <= ST_SEARCH;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= ST_UNSYNC;
            locked <= 1'b0;
          end
        endcase
      end else begin
        acc_cnt    <= cnt_n;
        acc_first  <= first_n;
        acc_second <= second_n;

        if (early_sync) begin
          state     <= ST_SEARCH;
          locked    <= 1'b0;
          match_cnt <= 4'd0;
        end else if ((state == ST_UNSYNC) && sync_in) begin
          state <= ST_SEARCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_slot_decoder.sv
module tb_pulse_slot_decoder;

  localparam int CNT_W       = 3;
  localparam int LOCK_FRAMES = 4;
  localparam int FRAME       = 1 << CNT_W;
`ifdef PULSE_SLOT_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sync_in = 1'b0;
  logic             pulse_in = 1'b0;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] slot_a;
  logic [CNT_W-1:0] slot_b;
  logic [1:0]       pulse_cnt;
  logic             frame_valid;
  logic             locked;
  logic             err;

  int total = 0;
  int bad   = 0;

  pulse_slot_decoder #(
    .CNT_W      (CNT_W),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .pulse_in   (pulse_in),
    .slot_a     (slot_a),
    .slot_b     (slot_b),
    .pulse_cnt  (pulse_cnt),
    .frame_valid(frame_valid),
    .locked     (locked),
    .err        (err)
`ifdef PULSE_SLOT_STICKY_ERR_EN
    ,
    .err_clr    (err_clr)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: framing phase, the list of pulsed slots in the
  // current frame, and the expected outputs.
  int m_phase;
  bit m_synced;
  int m_match;
  int q[$];
  int e_a, e_b, e_cnt;
  bit e_fv, e_lk, e_err;

  task automatic model_reset();
    m_phase  = 0;
    m_synced = 1'b0;
    m_match  = 0;
    q.delete();
    e_a = 0; e_b = 0; e_cnt = 0;
    e_fv = 1'b0; e_lk = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit p);
    int  cur, n, a, b, c;
    bit  early, evt, good, same;
    evt  = 1'b0;
    e_fv = 1'b0;
    cur  = s ? 0 : m_phase;
    early = s && (m_phase != 0) && m_synced;
    if (early) begin
      q.delete();
      evt     = 1'b1;
      e_lk    = 1'b0;
      m_match = 0;
    end
    if (s) m_synced = 1'b1;
    if (m_synced && p) q.push_back(cur);
    if (m_synced && cur == FRAME - 1) begin
      n    = q.size();
      c    = (n > 3) ? 3 : n;
      a    = (n >= 1) ? q[0] : 0;
      b    = (n >= 2) ? q[1] : a;
      good = (c == 1) || (c == 2);
      same = good && a == e_a && b == e_b && c == e_cnt;
      if (same) m_match = (m_match >= LOCK_FRAMES) ? LOCK_FRAMES : m_match + 1;
      else      m_match = good ? 1 : 0;
      if (e_lk) begin
        if (!same) begin
          e_lk = 1'b0;
          evt  = 1'b1;
        end
      end else begin
        if (!good) evt = 1'b1;
        if (m_match == LOCK_FRAMES) e_lk = 1'b1;
      end
      e_a = a; e_b = b; e_cnt = c;
      e_fv = 1'b1;
      q.delete();
    end
    m_phase = (cur + 1) % FRAME;
    e_err   = evt || (STICKY && e_err && !err_clr);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("slot_a",      8'(slot_a),      8'(e_a));
    chk("slot_b",      8'(slot_b),      8'(e_b));
    chk("pulse_cnt",   8'(pulse_cnt),   8'(e_cnt));
    chk("frame_valid", 8'(frame_valid), 8'(e_fv));
    chk("locked",      8'(locked),      8'(e_lk));
    chk("err",         8'(err),         8'(e_err));
  endtask

  // Checks the DUT against fixed values taken from the scenario.
  task automatic expect_frame(input string tag, input int a, input int b,
                              input int c, input bit lk, input bit er);
    chk({tag, "_fv"},  8'(frame_valid), 8'd1);
    chk({tag, "_a"},   8'(slot_a),      8'(a));
    chk({tag, "_b"},   8'(slot_b),      8'(b));
    chk({tag, "_cnt"}, 8'(pulse_cnt),   8'(c));
    chk({tag, "_lk"},  8'(locked),      8'(lk));
    chk({tag, "_err"}, 8'(err),         8'(er));
  endtask

  // Inputs change 1 time unit after a posedge. Outputs are sampled
  // 1 time unit after the next posedge.
  task automatic step(input bit s, input bit p);
    sync_in  = s;
    pulse_in = p;
    @(posedge clk);
    model_step(s, p);
    #1;
    check_all();
  endtask

  task automatic run_frame(input logic [7:0] mask);
    for (int i = 0; i < FRAME; i++) step(i == 0, mask[i]);
  endtask

  task automatic async_reset(input int hold);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_async_fv", 8'(frame_valid), 8'd0);
    for (int i = 0; i < hold; i++) begin
      sync_in  = 1'($urandom_range(0, 1));
      pulse_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_all();
    end
    rst = 1'b1;
  endtask

  localparam logic [7:0] P25  = 8'b0010_0100;
  localparam logic [7:0] P6   = 8'b0100_0000;
  localparam logic [7:0] P07  = 8'b1000_0001;
  localparam logic [7:0] P134 = 8'b0001_1010;

  logic [7:0] pats [4];
  logic [7:0] pat;
  bit         rs, rp;
  int         rcur;

  initial begin
    pats[0] = P25; pats[1] = P6; pats[2] = P07; pats[3] = P134;
    model_reset();

    #1 rst = 1'b0;
    #1 check_all();
    @(posedge clk);
    @(posedge clk);
    #1 check_all();
    rst = 1'b1;

    // Pulses before any sync are ignored.
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)));

    // Stable slots 2 and 5: lock on the 4th report.
    for (int f = 0; f < 4; f++) begin
      run_frame(P25);
      if (f == 2) chk("p25_f3_locked", 8'(locked), 8'd0);
    end
    expect_frame("p25_lock", 2, 5, 2, 1'b1, 1'b0);

    // Three pulses while locked: bad frame drops lock.
    run_frame(P134);
    expect_frame("three_pulses", 1, 3, 3, 1'b0, 1'b1);

    // Four more good frames are needed to lock again.
    for (int f = 0; f < 4; f++) begin
      run_frame(P25);
      if (f == 2) chk("relock_f3_locked", 8'(locked), 8'd0);
    end
    expect_frame("relock", 2, 5, 2, 1'b1, 1'b0);

    // Early sync at phase 4 while locked.
    for (int i = 0; i < 4; i++) step(i == 0, P25[i]);
    step(1'b1, 1'b0);
    chk("early_fv",  8'(frame_valid), 8'd0);
    chk("early_err", 8'(err),         8'd1);
    chk("early_lk",  8'(locked),      8'd0);
    for (int i = 1; i < FRAME; i++) step(1'b0, P25[i]);
    expect_frame("after_early", 2, 5, 2, 1'b0, 1'b0);

    // Single pulse at slot 6.
    for (int f = 0; f < 4; f++) run_frame(P6);
    expect_frame("slot6", 6, 6, 1, 1'b1, 1'b0);

    // Sync and pulse together at slot 0, plus slot 7.
    run_frame(P07);
    expect_frame("slot0_7", 0, 7, 2, 1'b0, 1'b1);

    // Mid-frame reset, then pulses ignored until the next sync.
    for (int i = 0; i < 3; i++) step(i == 0, P25[i]);
    async_reset(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("post_rst_fv", 8'(frame_valid), 8'd0);
    run_frame(P25);
    expect_frame("post_rst", 2, 5, 2, 1'b0, 1'b0);

    // Randomized framing, missing and early syncs, and noise pulses.
    pat = pats[$urandom_range(0, 3)];
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 3) == 0) pat = pats[$urandom_range(0, 3)];
      for (int i = 0; i < FRAME; i++) begin
        if (m_phase == 0) rs = ($urandom_range(0, 15) != 0);
        else              rs = ($urandom_range(0, 79) == 0);
        rcur = rs ? 0 : m_phase;
        rp   = pat[rcur] ^ ($urandom_range(0, 49) == 0);
        step(rs, rp);
      end
    end

`ifdef PULSE_SLOT_STICKY_ERR_EN
    async_reset(1);
    for (int f = 0; f < 4; f++) run_frame(P25);
    expect_frame("st_lock", 2, 5, 2, 1'b1, 1'b0);
    run_frame(8'h00);
    expect_frame("st_bad", 0, 0, 0, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++) run_frame(P25);
    chk("st_hold_err", 8'(err), 8'd1);
    err_clr = 1'b1;
    step(1'b0, 1'b0);
    err_clr = 1'b0;
    chk("st_clr_err", 8'(err), 8'd0);
    for (int i = 0; i < FRAME; i++) begin
      err_clr = (i == FRAME - 1);
      step(i == 0, 1'b0);
    end
    err_clr = 1'b0;
    chk("st_set_wins", 8'(err), 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_slot_decoder.md
Name: pulse_slot_decoder

Overview:
- Receive-side counterpart of the slot-gated clock-pulse generator: observes the gated pulse stream and recovers the frame slots the pulses occupy.
- Frame boundaries come from a slot-0 sync strobe; each frame has 2^CNT_W slots.
- Reports the decoded slot pair and pulse count, and indicates lock once the pattern is stable.
- Sits beside the processor clock-control logic as a monitor and checker for the divided-clock enables.

Parameters:
- CNT_W, 3: slot counter width; frame length is 2^CNT_W cycles.
- LOCK_FRAMES, 4: consecutive identical valid frames required to assert locked (range 1..15).

Ports:
- clk  input  1  system clock; all logic is on the posedge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- sync_in  input  1  high for one cycle during the slot-0 cycle of the generator's frame.
- pulse_in  input  1  gated pulse stream, sampled at each posedge; high means the current slot is pulsed.
- slot_a  output  CNT_W  lowest pulsed slot of the last completed frame.
- slot_b  output  CNT_W  second pulsed slot; equals slot_a when only one pulse occurred.
- pulse_cnt  output  2  pulses in the last frame: 0, 1 or 2; 3 means 3 or more (saturating).
- frame_valid  output  1  one-cycle strobe; slot_a, slot_b and pulse_cnt update on the same cycle.
- locked  output  1  pattern stable for LOCK_FRAMES frames.
- err  output  1  one-cycle strobe coincident with frame_valid (or with a resync, see below).

Behaviour:
- Reset (rst=0, asynchronous):
  - slot_a, slot_b, pulse_cnt, frame_valid, locked and err all 0.
  - Phase counter 0; state UNSYNC.
- Slot index of the current cycle:
  - cur = 0 when sync_in=1, otherwise phase.
  - Next cycle: phase = cur+1, wrapping modulo 2^CNT_W.
- States: UNSYNC, SEARCH, LOCKED.
  - UNSYNC: pulses are ignored and no frame_valid is produced. The first sync_in moves to SEARCH, and that cycle is slot 0 of the first frame.
- Per-frame capture:
  - On each pulse_in=1 at slot cur, the frame accumulator increments (saturating at 3).
  - The first pulse loads the first-slot register.
  - The second pulse loads the second-slot register.
  - Later pulses affect only the count.
- End of frame (cur = 2^CNT_W-1):
  - The accumulated values, including any pulse in the last slot, are registered to the outputs the following cycle, with frame_valid=1. Latency is 1 cycle after the last slot.
  - Frame accumulators then clear.
  - Output values for each count:
    - 0 pulses: slot_a=slot_b=0, pulse_cnt=0.
    - 1 pulse: slot_b=slot_a.
    - 3 or more pulses: the first two slots are reported, pulse_cnt=3.
- Frame classification:
  - Good frame: pulse_cnt is 1 or 2.
  - Bad frame: pulse_cnt is 0 or 3.
- Lock tracking:
  - Match counter (4 bits) compares each good frame with the previous reported frame on slot_a, slot_b and pulse_cnt.
  - Matching frame: counter increments, saturating at LOCK_FRAMES.
  - Mismatching good frame: counter resets to 1.
  - Bad frame: counter resets to 0.
  - SEARCH to LOCKED when the counter reaches LOCK_FRAMES; locked=1 in the same cycle as that frame_valid.
  - In LOCKED, a mismatching or bad frame moves to SEARCH: locked=0 and err=1 on that frame_valid, and the counter reloads as above.
- Bad frames also assert err=1 with frame_valid while in SEARCH.
- Early sync: sync_in=1 while phase≠0 (in SEARCH or LOCKED)
  - The partial frame is discarded: no frame_valid.
  - err=1 that cycle; locked=0; state becomes SEARCH; match counter 0.
  - That cycle becomes slot 0 of a new frame, and a pulse on it is captured.
- Missing sync: sync_in absent at the expected slot 0 is allowed; the counter free-runs.
- Simultaneous sync_in and pulse_in: the pulse is recorded at slot 0.
- Mid-operation reset: immediately returns to the reset values and UNSYNC.

Optional Feature:
- Macro: PULSE_SLOT_STICKY_ERR_EN.
- Defined:
  - Adds port err_clr (input, 1 bit).
  - err becomes sticky: it is set by any error event and cleared only by err_clr=1 or reset.
  - A set event on the same cycle as err_clr wins.
- Undefined:
  - No err_clr port.
  - err is the one-cycle strobe described in Behaviour.

Test Plan:
- Reset with CNT_W=3, then sync_in every 8 cycles, pulses at slots 2 and 5 -> each frame gives frame_valid with slot_a=2, slot_b=5, pulse_cnt=2; locked=1 on the 4th frame_valid; err never set.
- Pulse only at slot 6, 4 frames -> slot_a=slot_b=6, pulse_cnt=1, locked=1 on frame 4.
- While locked, one frame carries pulses at slots 1, 3 and 4 -> pulse_cnt=3, slot_a=1, slot_b=3, err=1, locked=0; return to slots 2/5 -> 4 more frames needed to relock.
- While locked, sync_in asserted at phase 4 -> no frame_valid for the partial frame, err=1, locked=0; the next frame, starting from the early sync, reports normally.
- Pulse at slot 7 plus sync_in and pulse together at slot 0 -> slot_a=0, slot_b=7, pulse_cnt=2; rst=0 mid-frame -> all outputs 0 asynchronously, pulses ignored until the next sync_in.
- With PULSE_SLOT_STICKY_ERR_EN defined, force a bad frame -> err stays 1 across following good frames until err_clr=1; err_clr on the same cycle as a new error -> err remains 1.
